mb_digit_decoder: RTL and testbench

Sequential radix-4 Modified Booth digit decoder: the inverse of `mb_encoder`. It accepts the 16 signed digits of one 32-bit operand, one per cycle, least-significant first. Each digit arrives as the same one/two/sign triple the encoder drives. The block accumulates Σ dᵢ·4ⁱ and returns the reconstructed 32-bit two's-complement word over a valid/ready handshake. It is used as a bit-exact round-trip checker for the encoder and as a recoded-operand unpacker ahead of the partial-product stage.

---
 rtl/mb_digit_decoder.sv | 144 ++++++++++++++
 tb/tb_mb_digit_decoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mb_digit_decoder.sv
// Sequential radix-4 Modified Booth digit decoder: rebuilds a 2*NDIG-bit word from
// one/two/sign digits arriving LSD first, and returns it over a valid/ready handshake.
module mb_digit_decoder #(
  parameter int NDIG = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_one,
  input  logic                in_two,
  input  logic                in_sign,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*NDIG-1:0]   out_data,
  output logic                out_err
);

  // state     | meaning
  // S_IDLE    | no digit of the current word taken yet; acc/cnt/err are zero
  // S_COLLECT | at least one digit taken, waiting for the rest
  // S_DONE    | word complete, presented on out_* until out_ready

  localparam int DW = 2 * NDIG;
  localparam int AW = DW + 2;
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic            err_q, err_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            out_err_q, out_err_d;

  logic [AW-1:0]   mag;
  logic [AW-1:0]   shifted;
  logic [AW-1:0]   term;
  logic            illegal;
  logic            accept;
  logic            last;

  // Digit term by shift and two's-complement negate; the illegal one=two=1 code adds 0.
  always_comb begin
    mag = '0;
    if (in_one && !in_two) begin
      mag = AW'(1);
    end else if (in_two && !in_one) begin
      mag = AW'(2);
    end
    shifted = mag << {cnt_q, 1'b0};
    term    = in_sign ? (~shifted + AW'(1)) : shifted;
  end

  assign illegal = in_one && in_two;
  assign accept  = in_valid && in_ready_q;
  assign last    = (cnt_q == CW'(NDIG - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    err_d       = err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;

    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (accept) begin
          acc_d   = acc_q + term;
          err_d   = err_q | illegal;
          cnt_d   = cnt_q + CW'(1);
          state_d = S_COLLECT;
          if (last) begin
            state_d     = S_DONE;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out_data_d  = acc_d[DW-1:0];
            out_err_d   = err_d;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          acc_d       = '0;
          err_d       = 1'b0;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          out_data_d  = '0;
          out_err_d   = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        cnt_d       = '0;
        acc_d       = '0;
        err_d       = 1'b0;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_mb_digit_decoder.sv
// Directed and round-trip bench for mb_digit_decoder; digits come from a reference
// Booth encoding of each word, and every word must decode back to itself.
module tb_mb_digit_decoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_one;
  logic        in_two;
  logic        in_sign;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;

  int n_checks;
  int n_errors;

  mb_digit_decoder #(.NDIG(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_one    (in_one),
    .in_two    (in_two),
    .in_sign   (in_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Radix-4 Booth digit i of word w: bits w[2i+1], w[2i], w[2i-1].
  function automatic void booth_digit(input logic [31:0] w, input int i,
                                      output logic o, output logic t, output logic s);
    logic [32:0] x;
    logic [2:0]  b;
    x = {w, 1'b0};
    b = x[2*i+2 -: 3];
    s = b[2];
    o = b[1] ^ b[0];
    t = (b == 3'b100) || (b == 3'b011);
  endfunction

  // Called and returning at a negedge; the handshake lands on the posedge in between.
  task automatic drive_digit(input logic o, input logic t, input logic s, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("in_ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    in_one   = o;
    in_two   = t;
    in_sign  = s;
    @(negedge clk);
    in_valid = 1'b0;
    in_one   = 1'b0;
    in_two   = 1'b0;
    in_sign  = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap, input int ndig);
    logic o, t, s;
    for (int i = 0; i < ndig; i++) begin
      booth_digit(w, i, o, t, s);
      drive_digit(o, t, s, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
  endtask

  // Waits for out_valid (out_ready already 1), samples, lets the handshake happen.
  task automatic wait_out(output logic [31:0] d, output logic e);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check_eq("out_valid_timeout", 32'd0, 32'd1);
    d = out_data;
    e = out_err;
    @(negedge clk);
  endtask

  task automatic check_word(input string tag, input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] d;
    logic        e;
    wait_out(d, e);
    check_eq({tag, "_data"}, d, exp_d);
    check_eq({tag, "_err"}, {31'd0, e}, {31'd0, exp_e});
  endtask

  logic [31:0] word;
  logic [31:0] hold_d;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_one    = 1'b0;
    in_two    = 1'b0;
    in_sign   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_data", out_data, 32'd0);
    check_eq("rst_out_err", {31'd0, out_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 16 zero digits back to back: out_valid exactly after the 16th handshake
    for (int i = 0; i < 15; i++) drive_digit(1'b0, 1'b0, 1'b0, 0);
    check_eq("zero_early_valid", {31'd0, out_valid}, 32'd0);
    drive_digit(1'b0, 1'b0, 1'b0, 0);
    check_eq("zero_latency_valid", {31'd0, out_valid}, 32'd1);
    check_eq("zero_done_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("zero_data", out_data, 32'd0);
    check_eq("zero_err", {31'd0, out_err}, 32'd0);
    @(negedge clk);
    check_eq("after_hs_valid", {31'd0, out_valid}, 32'd0);
    check_eq("after_hs_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("after_hs_data", out_data, 32'd0);

    for (int i = 0; i < 16; i++) drive_digit(i == 0, 1'b0, 1'b0, 0);
    check_word("d0_plus1", 32'h0000_0001, 1'b0);

    for (int i = 0; i < 16; i++) drive_digit(1'b0, i == 15, i == 15, 0);
    check_word("d15_minus2", 32'h8000_0000, 1'b0);

    for (int i = 0; i < 16; i++) drive_digit(1'b0, 1'b1, 1'b1, 0);
    check_word("all_minus2", 32'h5555_5556, 1'b0);

    send_word(32'h0e54_82fc, 3, 16);
    check_word("rt_0e5482fc", 32'h0e54_82fc, 1'b0);
    send_word(32'h2fc6_8201, 3, 16);
    check_word("rt_2fc68201", 32'h2fc6_8201, 1'b0);

    // Illegal digit 3 plus -0 codes elsewhere, held in DONE by backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 0) drive_digit(1'b1, 1'b0, 1'b0, 0);
      else if (i == 3) drive_digit(1'b1, 1'b1, 1'b0, 0);
      else drive_digit(1'b0, 1'b0, 1'b1, 0);
    end
    check_eq("bp_valid", {31'd0, out_valid}, 32'd1);
    check_eq("bp_data", out_data, 32'd1);
    check_eq("bp_err", {31'd0, out_err}, 32'd1);
    hold_d = out_data;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_hold_data", out_data, hold_d);
      check_eq("bp_hold_err", {31'd0, out_err}, 32'd1);
      check_eq("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    // A digit offered during the output handshake must not be taken
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_one    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_one   = 1'b0;
    check_eq("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check_eq("bp_release_err", {31'd0, out_err}, 32'd0);
    send_word(32'h1234_5678, 0, 16);
    check_word("no_stray_digit", 32'h1234_5678, 1'b0);

    // Reset mid-word discards the partial word
    send_word(32'hdead_beef, 0, 7);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("midrst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("midrst_data", out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_word(32'h0e54_82fc, 1, 16);
    check_word("post_rst_word", 32'h0e54_82fc, 1'b0);

    for (int r = 0; r < 1000; r++) begin
      word = $urandom;
      send_word(word, 0, 16);
      check_word("random", word, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
